// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit carry chain is
// cut into STAGES slices of SLICE bits, one slice resolved per register stage,
// with valid/ready flow control and full backpressure at both ends.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage registers: operands still to be processed, sum bits completed so
  // far, carry out of the slice just resolved, and occupancy.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;
  logic              zero_q;

  // Per-stage inputs and next values.
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nxt;
  logic [SLICE:0]    slice_sum;
  logic              ovf_nxt;
  logic              zero_nxt;

  // Flow control.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              room;
  logic              accept;

  // Advance/load enables. The recursive "next stage empty or advancing" rule
  // is unrolled into a downward scan: a stage may move when the output drains
  // or any stage above it is empty.
  always_comb begin
    adv  = '0;
    load = '0;
    room = bus.out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[LAST - i] = v_q[LAST - i] & room;
      room          = room | ~v_q[LAST - i];
    end
    accept  = bus.in_valid & (~v_q[0] | adv[0]);
    load[0] = accept;
    for (int unsigned k = 1; k < STAGES; k++) begin
      load[k] = adv[k - 1];
    end
  end

  // Slice arithmetic: stage k resolves bits [k*SLICE +: SLICE] from the carry
  // left by stage k-1; stage 0 works directly on the prepared operands.
  always_comb begin
    a_src[0] = bus.a;
    b_src[0] = bus.sub ? ~bus.b : bus.b;
    s_src[0] = '0;
    c_src    = '0;
    c_src[0] = bus.ci ^ bus.sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k - 1];
      b_src[k] = b_q[k - 1];
      s_src[k] = s_q[k - 1];
      c_src[k] = c_q[k - 1];
    end
    c_nxt     = '0;
    slice_sum = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_src[k][k*SLICE +: SLICE]}
                + {1'b0, b_src[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, c_src[k]};
      s_nxt[k]                  = s_src[k];
      s_nxt[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      c_nxt[k]                  = slice_sum[SLICE];
    end
    // Carry into the MSB is recovered as a^b^sum at that bit.
    ovf_nxt  = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1]
             ^ s_nxt[LAST][WIDTH-1] ^ c_nxt[LAST];
    zero_nxt = (s_nxt[LAST] == '0);
  end

  // Stage registers; data only moves on load, so a stalled stage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
        end
        v_q[k] <= load[k] | (v_q[k] & ~adv[k]);
      end
      if (load[LAST]) begin
        ovf_q  <= ovf_nxt;
        zero_q <= zero_nxt;
      end
    end
  end

  assign bus.in_ready  = ~v_q[0] | adv[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.co        = c_q[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
